aes_round_key_gen: RTL
======================

Name: aes_round_key_gen

Overview:
Key schedule block directly upstream of the AES decipher round. On an init pulse it expands a 128- or 256-bit cipher key into all round keys, at one round key per cycle. It stores the keys in an internal 15 x 128-bit memory. The decipher round reads any stored key combinationally through round_key_addr / round_key, in any order.

Parameters:
NUM_KEYS, 15, memory depth in 128-bit round keys (fixed for AES-256; not meant to be overridden)

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
init  input  1  single-cycle start pulse; sampled only in IDLE/DONE
key  input  256  cipher key; AES-128 uses key[255:128]
keylen  input  2  2'h0 = AES-128, 2'h2 = AES-256; 2'h1 and 2'h3 are illegal
round_key_addr  input  4  round key read index
round_key  output  128  memory[round_key_addr]; combinational read
ready  output  1  high when the whole schedule is valid
error  output  1  sticky flag; set by init with an illegal keylen
sboxw  output  32  word sent to the shared external 4-byte S-box
new_sboxw  input  32  S-box result; combinational, same cycle

Behaviour:
- Reset (asynchronous, reset_n low):
  - All 15 memory entries = 0; prev_key0/prev_key1 = 0; round_ctr = 0; rcon = 8'h8d.
  - ready = 0; error = 0; state = IDLE; sboxw = prev_key1[31:0] = 0.
- States and transitions:
  - IDLE/DONE + init + legal keylen -> GEN. That edge latches keylen_reg, clears round_ctr and error, and drops ready.
  - IDLE/DONE + init + illegal keylen -> error = 1. Memory, ready and state are unchanged.
  - In GEN, init is ignored.
- GEN: exactly one memory write per cycle, at address round_ctr, then round_ctr increments.
  - Last index is 10 for AES-128 and 14 for AES-256. After writing it: state -> DONE and ready = 1 on the same edge.
  - init->ready latency is 12 rising edges for AES-128 and 16 for AES-256, counting the init edge as 1.
- Key generation: w0..w3 are the MSW..LSW of a 128-bit key. sboxw is always prev_key1[31:0].
  - AES-128, ctr 0: write key[255:128]. ctr >= 1: rcon advances (8d->01->02->04->08->10->20->40->80->1b->36, via xtime), then:
    - t = rotl8(new_sboxw) ^ {rcon_next, 24'h0}
    - w0' = w0 ^ t, w1' = w1 ^ w0', w2' = w2 ^ w1', w3' = w3 ^ w2', where w is prev_key1.
  - AES-256, ctr 0: write key[255:128]. ctr 1: write key[127:0].
  - AES-256, ctr >= 2 even: rcon advances; t = rotl8(new_sboxw) ^ {rcon_next, 24'h0}; the chain above runs on prev_key0's words.
  - AES-256, ctr >= 2 odd: rcon held; t = new_sboxw (no rotation, no rcon); the chain runs on prev_key0's words.
  - Every write: prev_key0 <= prev_key1, prev_key1 <= written key.
- Read port: round_key = memory[round_key_addr] with no latency.
  - Addresses 15 and above return 128'h0.
  - Reads during GEN return whatever is currently stored, including stale entries from the previous schedule.
- ready is low throughout GEN and is never high while any entry is stale.
- Reset mid-GEN: immediate return to the reset values. A partially written schedule is cleared.

Optional Feature:
- Macro: AES_KEYMEM_CLEAR_EN.
- Defined: adds input port clear (1 bit). When clear is high in any state, the next edge zeroes all memory entries, prev_key0/1 and rcon = 8'h8d; it also sets ready = 0, state = IDLE and error = 0. clear has priority over init in the same cycle.
- Undefined: the port is absent, and entries persist until overwritten by a new init or reset.

Test Plan:
- Reset -> ready = 0, error = 0, round_key = 128'h0 for every address 0..15.
- AES-128: key[255:128] = 2b7e151628aed2a6abf7158809cf4f3c, init -> ready high 12 edges after init. Required keys:
  - addr 0 = 2b7e151628aed2a6abf7158809cf4f3c
  - addr 1 = a0fafe1788542cb123a339392a6c7605
  - addr 10 = d014f9a8c9ee2589e13f0cc8b6630ca6
- AES-256: key = 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> ready after 16 edges. Required keys:
  - addr 2 = 9ba354118e6925afa51a8b5f2067fcde
  - addr 14 = fe4890d1e6188d0b046df344706c631e
- init with keylen = 2'h1 while DONE -> error = 1; ready stays 1; addr 10 is unchanged. A following legal init clears error.
- Second init pulse 3 cycles into GEN -> ignored; ready rises exactly on the original cycle count with correct keys.
- reset_n pulsed low at ctr 6 of an AES-256 run -> all outputs return to reset values immediately; a re-init completes correctly.

Source files
------------

// File: rtl/aes_round_key_gen.sv
// AES key schedule: expands a 128/256-bit cipher key into up to 15 round keys,
// one per cycle, and serves them through a combinational read port.
// Optional feature macro: AES_KEYMEM_CLEAR_EN adds a synchronous 'clear' input
// that wipes the key memory and returns the block to IDLE.
module aes_round_key_gen #(
  parameter int unsigned NUM_KEYS = 15
) (
  input  logic         clk,
  input  logic         reset_n,
`ifdef AES_KEYMEM_CLEAR_EN
  input  logic         clear,
`endif
  input  logic         init,
  input  logic [255:0] key,
  input  logic [1:0]   keylen,
  input  logic [3:0]   round_key_addr,
  output logic [127:0] round_key,
  output logic         ready,
  output logic         error,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw
);

  typedef enum logic [1:0] {StIdle, StGen, StDone} state_e;

  localparam logic [3:0] LastAddr = 4'(NUM_KEYS - 1);
  localparam logic [3:0] Last128  = 4'd10;
  localparam logic [3:0] Last256  = 4'd14;
  localparam logic [7:0] RconInit = 8'h8d;

  state_e         state_q, state_d;
  logic [127:0]   mem_q [NUM_KEYS];
  logic [127:0]   prev_key0_q, prev_key1_q;
  logic [3:0]     round_ctr_q;
  logic [7:0]     rcon_q;
  logic           aes256_q;
  logic           ready_q, error_q;

  logic           clear_int;
  logic           start, err_set, gen_we, last;
  logic [7:0]     rcon_next;
  logic           rcon_adv;
  logic [127:0]   base;
  logic [31:0]    t, w0, w1, w2, w3;
  logic [127:0]   new_key;

`ifdef AES_KEYMEM_CLEAR_EN
  assign clear_int = clear;
`else
  assign clear_int = 1'b0;
`endif

  assign sboxw = prev_key1_q[31:0];
  assign ready = ready_q;
  assign error = error_q;

  // Combinational read; out-of-range addresses return zero.
  always_comb begin
    round_key = '0;
    if (round_key_addr <= LastAddr) round_key = mem_q[round_key_addr];
  end

  // Next round key: AES-128 chains on the previous key, AES-256 on the one before it.
  always_comb begin
    rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    base      = aes256_q ? prev_key0_q : prev_key1_q;
    // AES-256 odd steps use SubWord only, without rotation or rcon.
    if (aes256_q && round_ctr_q[0]) begin
      t = new_sboxw;
    end else begin
      t = {new_sboxw[23:0], new_sboxw[31:24]} ^ {rcon_next, 24'h0};
    end
    w0 = base[127:96] ^ t;
    w1 = base[95:64]  ^ w0;
    w2 = base[63:32]  ^ w1;
    w3 = base[31:0]   ^ w2;
    rcon_adv = 1'b0;
    if (round_ctr_q == 4'd0) begin
      new_key = key[255:128];
    end else if (aes256_q && round_ctr_q == 4'd1) begin
      new_key = key[127:0];
    end else begin
      new_key  = {w0, w1, w2, w3};
      rcon_adv = !(aes256_q && round_ctr_q[0]);
    end
  end

  // FSM next state and control strobes.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    err_set = 1'b0;
    gen_we  = 1'b0;
    last    = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (init) begin
          if (keylen == 2'h0 || keylen == 2'h2) begin
            start   = 1'b1;
            state_d = StGen;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      StGen: begin
        gen_we = 1'b1;
        last   = (round_ctr_q == (aes256_q ? Last256 : Last128));
        if (last) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
    if (clear_int) begin
      state_d = StIdle;
      start   = 1'b0;
      err_set = 1'b0;
      gen_we  = 1'b0;
      last    = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Schedule control registers: counter, rcon, key history and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_key0_q <= '0;
      prev_key1_q <= '0;
      round_ctr_q <= '0;
      rcon_q      <= RconInit;
      aes256_q    <= 1'b0;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
    end else if (clear_int) begin
      prev_key0_q <= '0;
      prev_key1_q <= '0;
      round_ctr_q <= '0;
      rcon_q      <= RconInit;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      if (start) begin
        aes256_q    <= keylen[1];
        round_ctr_q <= '0;
        rcon_q      <= RconInit;
        ready_q     <= 1'b0;
        error_q     <= 1'b0;
      end
      if (err_set) error_q <= 1'b1;
      if (gen_we) begin
        prev_key0_q <= prev_key1_q;
        prev_key1_q <= new_key;
        round_ctr_q <= round_ctr_q + 4'd1;
        if (rcon_adv) rcon_q <= rcon_next;
        if (last) ready_q <= 1'b1;
      end
    end
  end

  // Round key memory: one entry written per GEN cycle at round_ctr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_KEYS; i++) mem_q[i] <= '0;
    end else if (clear_int) begin
      for (int i = 0; i < NUM_KEYS; i++) mem_q[i] <= '0;
    end else if (gen_we) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (round_ctr_q == 4'(i)) mem_q[i] <= new_key;
      end
    end
  end

endmodule
